// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C request arbiter:
//   - arb_state_e : arbiter FSM state encoding
//   - SLAVE_W / REG_W / DATA_W : handler transaction field widths
//   - idx_width() : index width for a count of items, never below 1 bit
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_e;

    localparam int SLAVE_W = 7;
    localparam int REG_W   = 8;
    localparam int DATA_W  = 8;

    // Width needed to index n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr, wrapping at N_REQ (not at a power of two).
// Ports:
//   req       in  N_REQ   request vector
//   ptr       in  IDX_W   index where the search starts (must be < N_REQ)
//   grant     out IDX_W   winning index (0 when nothing is requested)
//   any_valid out 1       at least one request bit is set
// ---------------------------------------------------------------------------
module rr_priority_pick
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_valid
);

    // One extra bit so ptr + offset (at most 2*N_REQ-2) never overflows.
    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;

    // Rotating priority search starting at ptr.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s     = {1'b0, ptr} + (IDX_W+1)'(k);
            idx_s     = (sum_s >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum_s - (IDX_W+1)'(N_REQ))
                                                      : IDX_W'(sum_s);
            grant     = (!any_valid && req[idx_s]) ? idx_s : grant;
            any_valid = any_valid | req[idx_s];
        end
    end

endmodule

// File: rtl/i2c_request_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_request_arbiter
// Shares one I2C register-transaction handler between N_REQ requesters.
// Round-robin grant in IDLE, latch the winner's transaction fields, pulse the
// handler's begin, wait for done (or give up after TIMEOUT_CYCLES), then
// return a one-cycle ack (+ timeout flag) to the winner.
// Ports:
//   i_clk, i_rst_n              clock; synchronous active-low reset
//   i_req/i_we      [N_REQ]     per-requester request level / write flag
//   i_slaveAddr     [7*N_REQ]   per-requester slave address, slice [7n+:7]
//   i_regAddr       [8*N_REQ]   per-requester register address, slice [8n+:8]
//   i_txData        [8*N_REQ]   per-requester write data, slice [8n+:8]
//   o_ack/o_timeout [N_REQ]     completion pulse and error flag to the winner
//   o_busy                      high whenever the FSM is not IDLE
//   o_hBegin                    one-cycle start pulse to the handler
//   o_hWriteEnable/o_hI2cAddress/o_hRegAddress/o_hTxData  latched fields
//   i_hDone                     one-cycle completion pulse from the handler
// All outputs are registered.
// ---------------------------------------------------------------------------
module i2c_request_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_we,
    input  logic [SLAVE_W*N_REQ-1:0] i_slaveAddr,
    input  logic [REG_W*N_REQ-1:0]   i_regAddr,
    input  logic [DATA_W*N_REQ-1:0]  i_txData,
    output logic [N_REQ-1:0]         o_ack,
    output logic [N_REQ-1:0]         o_timeout,
    output logic                     o_busy,
    output logic                     o_hBegin,
    output logic                     o_hWriteEnable,
    output logic [SLAVE_W-1:0]       o_hI2cAddress,
    output logic [REG_W-1:0]         o_hRegAddress,
    output logic [DATA_W-1:0]        o_hTxData,
    input  logic                     i_hDone
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT_BASE  = N_REQ'(1);

    arb_state_e         state_r;
    arb_state_e         state_next_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   grant_r;
    logic [IDX_W-1:0]   pick_s;
    logic               any_valid_s;
    logic [CNT_W-1:0]   count_r;
    logic               timeout_hit_s;
    logic [N_REQ-1:0]   grant_onehot_s;
    logic [N_REQ-1:0]   ack_next_s;
    logic [N_REQ-1:0]   timeout_next_s;
    logic               begin_next_s;
    logic               busy_next_s;

    logic [SLAVE_W-1:0] slave_arr_s [N_REQ];
    logic [REG_W-1:0]   reg_arr_s   [N_REQ];
    logic [DATA_W-1:0]  data_arr_s  [N_REQ];

    // Split the packed per-requester buses into indexable arrays.
    for (genvar n = 0; n < N_REQ; n++) begin : g_unpack
        assign slave_arr_s[n] = i_slaveAddr[n*SLAVE_W +: SLAVE_W];
        assign reg_arr_s[n]   = i_regAddr[n*REG_W +: REG_W];
        assign data_arr_s[n]  = i_txData[n*DATA_W +: DATA_W];
    end

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (i_req),
        .ptr       (ptr_r),
        .grant     (pick_s),
        .any_valid (any_valid_s)
    );

    assign timeout_hit_s  = (count_r == CNT_LAST);
    assign grant_onehot_s = ONE_HOT_BASE << grant_r;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; done beats the timeout when both land together.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (any_valid_s) begin
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: state_next_s = S_WAIT;
            S_WAIT: begin
                if (i_hDone || timeout_hit_s) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESP:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM output decode: next values for the registered control outputs.
    // Begin is registered out of ISSUE so it lands two edges after the
    // request is sampled; ack/timeout are registered on the WAIT->RESP move
    // so they appear one edge after done.
    always_comb begin
        ack_next_s     = '0;
        timeout_next_s = '0;
        begin_next_s   = 1'b0;
        busy_next_s    = (state_next_s != S_IDLE);
        case (state_r)
            S_ISSUE: begin_next_s = 1'b1;
            S_WAIT: begin
                if (state_next_s == S_RESP) begin
                    ack_next_s     = grant_onehot_s;
                    timeout_next_s = i_hDone ? '0 : grant_onehot_s;
                end else begin
                    ack_next_s     = '0;
                    timeout_next_s = '0;
                end
            end
            default: begin_next_s = 1'b0;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ack     <= '0;
            o_timeout <= '0;
            o_hBegin  <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_ack     <= ack_next_s;
            o_timeout <= timeout_next_s;
            o_hBegin  <= begin_next_s;
            o_busy    <= busy_next_s;
        end
    end

    // Grant/field latches, timeout counter and round-robin pointer.
    // Fields are captured only in IDLE and then held, because the handler
    // reads the slave address live for the whole transaction.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_r          <= '0;
            grant_r        <= '0;
            count_r        <= '0;
            o_hWriteEnable <= 1'b0;
            o_hI2cAddress  <= '0;
            o_hRegAddress  <= '0;
            o_hTxData      <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (any_valid_s) begin
                        grant_r        <= pick_s;
                        o_hWriteEnable <= i_we[pick_s];
                        o_hI2cAddress  <= slave_arr_s[pick_s];
                        o_hRegAddress  <= reg_arr_s[pick_s];
                        o_hTxData      <= data_arr_s[pick_s];
                    end
                end
                S_ISSUE: count_r <= '0;
                S_WAIT: begin
                    if (!i_hDone && !timeout_hit_s) begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                S_RESP: ptr_r <= (grant_r == IDX_LAST) ? '0 : grant_r + IDX_W'(1);
                default: ptr_r <= ptr_r;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_request_arbiter
// Self-checking bench. dut_a uses the default timeout; dut_t uses
// TIMEOUT_CYCLES=16 for the timeout corner cases. Both share the stimulus and
// are reset before every scenario; only the DUT under test is checked.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_i2c_request_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [20:0] sa;
    logic [23:0] ra;
    logic [23:0] td;
    logic        done;

    logic [2:0] a_ack, a_to, t_ack, t_to;
    logic       a_busy, a_begin, a_we, t_busy, t_begin, t_we;
    logic [6:0] a_sa, t_sa;
    logic [7:0] a_ra, a_td, t_ra, t_td;

    logic       sel_t;
    logic [2:0] cur_ack, cur_to;
    logic       cur_begin, cur_busy;
    logic [23:0] cur_fields;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    i2c_request_arbiter #(.N_REQ(3)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we),
        .i_slaveAddr(sa), .i_regAddr(ra), .i_txData(td),
        .o_ack(a_ack), .o_timeout(a_to), .o_busy(a_busy), .o_hBegin(a_begin),
        .o_hWriteEnable(a_we), .o_hI2cAddress(a_sa), .o_hRegAddress(a_ra),
        .o_hTxData(a_td), .i_hDone(done)
    );

    i2c_request_arbiter #(.N_REQ(3), .TIMEOUT_CYCLES(16)) dut_t (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we),
        .i_slaveAddr(sa), .i_regAddr(ra), .i_txData(td),
        .o_ack(t_ack), .o_timeout(t_to), .o_busy(t_busy), .o_hBegin(t_begin),
        .o_hWriteEnable(t_we), .o_hI2cAddress(t_sa), .o_hRegAddress(t_ra),
        .o_hTxData(t_td), .i_hDone(done)
    );

    assign cur_ack    = sel_t ? t_ack   : a_ack;
    assign cur_to     = sel_t ? t_to    : a_to;
    assign cur_begin  = sel_t ? t_begin : a_begin;
    assign cur_busy   = sel_t ? t_busy  : a_busy;
    assign cur_fields = sel_t ? {t_we, t_sa, t_ra, t_td} : {a_we, a_sa, a_ra, a_td};

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [20:0] sa;
        logic [23:0] ra;
        logic [23:0] td;
        int          delay;
        logic [23:0] exp_fields;
        logic [2:0]  exp_ack;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        req   = 3'b000;
        done  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_begin(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cur_begin) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Serve one grant on the selected DUT: expect requester idx, done after delay.
    task automatic serve(input int idx, input int delay);
        bit          ok;
        logic [23:0] exp_f;
        logic [2:0]  oh;
        exp_f = {we[idx], sa[idx*7 +: 7], ra[idx*8 +: 8], td[idx*8 +: 8]};
        oh    = 3'b001 << idx;
        wait_begin(ok);
        check("begin_seen", 32'(ok), 32'd1);
        check("grant_fields", 32'(cur_fields), 32'(exp_f));
        repeat (delay - 1) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("serve_ack", 32'(cur_ack), 32'(oh));
        check("serve_timeout", 32'(cur_to), 32'd0);
        req[idx] = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        we  = v.we;
        sa  = v.sa;
        ra  = v.ra;
        td  = v.td;
        req = v.req;
        @(negedge clk);
        check("vec_busy_e1", 32'(a_busy), 32'd1);
        check("vec_begin_e1", 32'(a_begin), 32'd0);
        @(negedge clk);
        check("vec_begin_e2", 32'(a_begin), 32'd1);
        check("vec_fields", 32'({a_we, a_sa, a_ra, a_td}), 32'(v.exp_fields));
        for (int i = 1; i < v.delay; i++) begin
            @(negedge clk);
            if (i == 1) check("vec_begin_end", 32'(a_begin), 32'd0);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("vec_ack", 32'(a_ack), 32'(v.exp_ack));
        check("vec_timeout", 32'(a_to), 32'd0);
        req = 3'b000;
        @(negedge clk);
        check("vec_ack_pulse", 32'(a_ack), 32'd0);
        check("vec_idle", 32'(a_busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          flag;
        bit          flag2;
        logic [23:0] exp_f;

        vecs[0] = '{3'b010, 3'b010, {7'h11, 7'h48, 7'h22}, {8'h33, 8'h05, 8'h44},
                    {8'h55, 8'hA5, 8'h66}, 20, {1'b1, 7'h48, 8'h05, 8'hA5}, 3'b010};
        vecs[1] = '{3'b001, 3'b110, {7'h11, 7'h48, 7'h50}, {8'h33, 8'h05, 8'h10},
                    {8'h55, 8'hA5, 8'hC3}, 3, {1'b0, 7'h50, 8'h10, 8'hC3}, 3'b001};
        vecs[2] = '{3'b100, 3'b100, {7'h7F, 7'h01, 7'h02}, {8'hFF, 8'h03, 8'h04},
                    {8'h5A, 8'h07, 8'h08}, 2, {1'b1, 7'h7F, 8'hFF, 8'h5A}, 3'b100};
        vecs[3] = '{3'b110, 3'b100, {7'h3C, 7'h2B, 7'h1A}, {8'hC2, 8'hB1, 8'hA0},
                    {8'h9F, 8'h8E, 8'h7D}, 5, {1'b0, 7'h2B, 8'hB1, 8'h8E}, 3'b010};

        rst_n = 1'b0; req = 3'b000; done = 1'b0; sel_t = 1'b0;
        we = 3'b000; sa = '0; ra = '0; td = '0;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check("reset_outputs_a", {a_ack, a_to, a_busy, a_begin, a_we, a_sa, a_ra, a_td}, 32'd0);
        check("reset_outputs_t", {t_ack, t_to, t_busy, t_begin, t_we, t_sa, t_ra, t_td}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({a_busy, a_begin}), 32'd0);

        // Table of single transactions from reset (pointer 0).
        for (int v = 0; v < 4; v++) begin
            do_reset();
            run_vector(vecs[v]);
        end

        // Contention: all three request, served 0,1,2; then 0 and 2 -> 0.
        do_reset();
        sel_t = 1'b0;
        we = 3'b101;
        sa = {7'h03, 7'h02, 7'h01};
        ra = {8'h13, 8'h12, 8'h11};
        td = {8'h23, 8'h22, 8'h21};
        req = 3'b111;
        serve(0, 3);
        serve(1, 3);
        serve(2, 3);
        @(negedge clk);
        check("contention_idle", 32'(a_busy), 32'd0);
        req = 3'b101;
        serve(0, 2);
        req = 3'b000;

        // Timeout with no done; a late done in RESP is ignored.
        do_reset();
        sel_t = 1'b1;
        req = 3'b001;
        wait_begin(ok);
        check("to_begin_seen", 32'(ok), 32'd1);
        flag = 1'b0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (t_ack != 3'b000) flag = 1'b1;
        end
        check("to_no_early_ack", 32'(flag), 32'd0);
        @(negedge clk);
        check("to_ack", 32'(t_ack), 32'd1);
        check("to_flag", 32'(t_to), 32'd1);
        req  = 3'b000;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("late_done_ack", 32'(t_ack), 32'd0);
        check("late_done_busy", 32'(t_busy), 32'd0);
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (t_busy || t_begin || t_ack != 3'b000) flag = 1'b1;
        end
        check("late_done_no_retry", 32'(flag), 32'd0);

        // Done on the last timeout cycle wins.
        do_reset();
        sel_t = 1'b1;
        req = 3'b001;
        wait_begin(ok);
        check("last_begin_seen", 32'(ok), 32'd1);
        repeat (15) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("last_cycle_ack", 32'(t_ack), 32'd1);
        check("last_cycle_timeout", 32'(t_to), 32'd0);
        req = 3'b000;

        // Field stability during WAIT.
        do_reset();
        sel_t = 1'b0;
        we = 3'b001;
        sa = {7'h0A, 7'h0B, 7'h0C};
        ra = {8'h1A, 8'h1B, 8'h1C};
        td = {8'h2A, 8'h2B, 8'h2C};
        req = 3'b101;
        exp_f = {1'b1, 7'h0C, 8'h1C, 8'h2C};
        wait_begin(ok);
        check("stab_begin_seen", 32'(ok), 32'd1);
        check("stab_fields", 32'({a_we, a_sa, a_ra, a_td}), 32'(exp_f));
        we[0] = 1'b0; sa[6:0] = 7'h55; ra[7:0] = 8'hEE; td[7:0] = 8'h99;
        req[2] = 1'b0;
        flag = 1'b0;
        flag2 = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if ({a_we, a_sa, a_ra, a_td} != exp_f) flag = 1'b1;
            if (a_begin) flag2 = 1'b1;
        end
        check("stab_fields_held", 32'(flag), 32'd0);
        check("stab_no_extra_begin", 32'(flag2), 32'd0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("stab_ack", 32'(a_ack), 32'd1);
        req = 3'b000;
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_busy) flag = 1'b1;
        end
        check("stab_dropped_req_unserved", 32'(flag), 32'd0);

        // Reset mid-WAIT: outputs clear at once, pointer returns to 0.
        do_reset();
        sel_t = 1'b0;
        we = 3'b010;
        sa = {7'h61, 7'h62, 7'h63};
        ra = {8'h71, 8'h72, 8'h73};
        td = {8'h81, 8'h82, 8'h83};
        req = 3'b001;
        serve(0, 2);
        req = 3'b011;
        wait_begin(ok);
        check("rst_begin_seen", 32'(ok), 32'd1);
        check("rst_grant1_fields", 32'({a_we, a_sa, a_ra, a_td}),
              32'({1'b1, 7'h62, 8'h72, 8'h82}));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_wait_reset_outputs", {a_ack, a_to, a_busy, a_begin, a_we, a_sa, a_ra, a_td}, 32'd0);
        rst_n = 1'b1;
        serve(0, 2);
        req = 3'b000;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
